multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a 16-bit multicycle datapath (fetch/decode/execute/writeback).
// Optional memory wait states: define MULTICYCLE_CTRL_WAIT_EN to add the mem_ready handshake.
module multicycle_ctrl #(
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
`ifdef MULTICYCLE_CTRL_WAIT_EN
  input  logic            mem_ready,
`endif
  output logic            iord,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regdst,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      aluop,
  output logic [1:0]      pcsrc,
  output logic            pc_en,
  output logic            illegal,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       waits;
  } ctrl_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(4);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(5);

  state_t cur;
  state_t nxt;
  ctrl_t  ctrl;
  logic   mem_done;
  logic   legal;
  logic   hold;
  logic   pcwrite;

`ifdef MULTICYCLE_CTRL_WAIT_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.waits   = 1'b1;
      end
      DECODE: c.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD: begin
        c.iord  = 1'b1;
        c.waits = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
        c.waits    = 1'b1;
      end
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      ADDIWB: c.regwrite = 1'b1;
      RTEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      RTWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQ: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
                 (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = mem_done ? DECODE : FETCH;
      DECODE: begin
        if (op == OP_LW || op == OP_SW) nxt = MEMADR;
        else if (op == OP_R)            nxt = RTEX;
        else if (op == OP_BEQ)          nxt = BEQ;
        else if (op == OP_ADDI)         nxt = ADDIEX;
        else if (op == OP_J)            nxt = JUMP;
        else                            nxt = FETCH;
      end
      MEMADR: nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nxt = mem_done ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_done ? FETCH : MEMWR;
      RTEX:   nxt = RTWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  // Controls are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur  <= FETCH;
      ctrl <= decode(FETCH);
    end else begin
      cur  <= nxt;
      ctrl <= decode(nxt);
    end
  end

  // Write strobes in a memory-wait state fire only in the cycle memory completes.
  assign hold     = ctrl.waits & ~mem_done;
  assign pcwrite  = ctrl.pcwrite & ~hold;
  assign irwrite  = ctrl.irwrite & ~hold;
  assign memwrite = ctrl.memwrite & ~hold;
  assign iord     = ctrl.iord;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsrc    = ctrl.pcsrc;
  assign pc_en    = pcwrite | (ctrl.branch & zero);
  assign illegal  = (cur == DECODE) & ~legal;
  assign state    = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected state/controls are queued per instruction.
// Define MULTICYCLE_CTRL_WAIT_EN to also exercise the memory wait-state scenarios.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] opIn;
  logic       zeroIn;
  logic       memReady;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pc_en, illegal;
  logic [3:0] state;
  logic [14:0] dutOuts;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] outs;
    logic        mr;
    string       tag;
  } entry_t;

  entry_t sb[$];
  string  curName;
  int     cycleIdx;

  multicycle_ctrl #(.OP_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (opIn),
    .zero     (zeroIn),
`ifdef MULTICYCLE_CTRL_WAIT_EN
    .mem_ready(memReady),
`endif
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .aluop    (aluop),
    .pcsrc    (pcsrc),
    .pc_en    (pc_en),
    .illegal  (illegal),
    .state    (state)
  );

  assign dutOuts = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                    alusrcb, aluop, pcsrc, pc_en, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Expected control bundle for a state, from the documented per-state table.
  function automatic logic [14:0] expOuts(input logic [3:0] st, input logic z,
                                          input logic ill, input logic mr);
    logic io, mw, ir, rd, mtr, rw, asa, pe;
    logic [1:0] asb, aop, psrc;
    {io, mw, ir, rd, mtr, rw, asa, pe} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin ir = mr; asb = 2'b01; pe = mr; end
      4'd1:  asb = 2'b11;
      4'd2, 4'd9: begin asa = 1'b1; asb = 2'b10; end
      4'd3:  io = 1'b1;
      4'd4:  begin mtr = 1'b1; rw = 1'b1; end
      4'd5:  begin io = 1'b1; mw = mr; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pe = z; end
      4'd10: rw = 1'b1;
      4'd11: begin psrc = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {io, mw, ir, rd, mtr, rw, asa, asb, aop, psrc, pe, ill};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic pushCycle(input logic [3:0] st, input logic ill, input logic mr);
    entry_t e;
    e.st   = st;
    e.outs = expOuts(st, zeroIn, ill, mr);
    e.mr   = mr;
    e.tag  = $sformatf("%s c%0d", curName, cycleIdx);
    cycleIdx++;
    sb.push_back(e);
  endtask

  // Drive an instruction and queue the state sequence it should walk through.
  task automatic applyStimulus(input string name, input logic [3:0] o, input logic z,
                               input int memWaits);
    curName  = name;
    cycleIdx = 0;
    opIn     = o;
    zeroIn   = z;
    pushCycle(4'd0, 1'b0, 1'b1);
    pushCycle(4'd1, (o > 4'd5), 1'b1);
    case (o)
      4'd0: begin pushCycle(4'd6, 1'b0, 1'b1); pushCycle(4'd7, 1'b0, 1'b1); end
      4'd1: begin
        pushCycle(4'd2, 1'b0, 1'b1);
        for (int i = 0; i < memWaits; i++) pushCycle(4'd3, 1'b0, 1'b0);
        pushCycle(4'd3, 1'b0, 1'b1);
        pushCycle(4'd4, 1'b0, 1'b1);
      end
      4'd2: begin
        pushCycle(4'd2, 1'b0, 1'b1);
        for (int i = 0; i < memWaits; i++) pushCycle(4'd5, 1'b0, 1'b0);
        pushCycle(4'd5, 1'b0, 1'b1);
      end
      4'd3: pushCycle(4'd8, 1'b0, 1'b1);
      4'd4: begin pushCycle(4'd9, 1'b0, 1'b1); pushCycle(4'd10, 1'b0, 1'b1); end
      4'd5: pushCycle(4'd11, 1'b0, 1'b1);
      default: ;
    endcase
  endtask

  // One queue entry per DUT cycle; entered just after a rising edge.
  task automatic drainQueue();
    entry_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      memReady = e.mr;
      @(negedge clk);
      checkOutput({e.tag, " state"}, {28'd0, state}, {28'd0, e.st});
      checkOutput({e.tag, " outs"}, {17'd0, dutOuts}, {17'd0, e.outs});
      @(posedge clk);
      #1;
    end
    memReady = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    opIn     = 4'd0;
    zeroIn   = 1'b0;
    memReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", {28'd0, state}, 32'd0);
    checkOutput("reset outs", {17'd0, dutOuts}, {17'd0, expOuts(4'd0, 1'b0, 1'b0, 1'b1)});
    reset = 1'b0;

    applyStimulus("lw", 4'd1, 1'b0, 0);     drainQueue();
    applyStimulus("sw", 4'd2, 1'b0, 0);     drainQueue();
    applyStimulus("rtype", 4'd0, 1'b1, 0);  drainQueue();
    applyStimulus("addi", 4'd4, 1'b0, 0);   drainQueue();
    applyStimulus("beq_z1", 4'd3, 1'b1, 0); drainQueue();
    applyStimulus("beq_z0", 4'd3, 1'b0, 0); drainQueue();
    applyStimulus("jump", 4'd5, 1'b0, 0);   drainQueue();
    applyStimulus("ill_f", 4'd15, 1'b0, 0); drainQueue();
    applyStimulus("ill_6", 4'd6, 1'b1, 0);  drainQueue();

    // Asynchronous reset while the R-type instruction sits in RTEX.
    curName  = "rst_mid";
    cycleIdx = 0;
    opIn     = 4'd0;
    zeroIn   = 1'b0;
    pushCycle(4'd0, 1'b0, 1'b1);
    pushCycle(4'd1, 1'b0, 1'b1);
    drainQueue();
    @(negedge clk);
    checkOutput("rst_mid pre state", {28'd0, state}, 32'd6);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid state", {28'd0, state}, 32'd0);
    checkOutput("rst_mid irwrite", {31'd0, irwrite}, 32'd1);
    checkOutput("rst_mid pc_en", {31'd0, pc_en}, 32'd1);
    checkOutput("rst_mid regwrite", {31'd0, regwrite}, 32'd0);
    checkOutput("rst_mid illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus("jump2", 4'd5, 1'b0, 0);  drainQueue();
    applyStimulus("rtype2", 4'd0, 1'b0, 0); drainQueue();

`ifdef MULTICYCLE_CTRL_WAIT_EN
    applyStimulus("sw_wait", 4'd2, 1'b0, 3); drainQueue();
    applyStimulus("lw_wait", 4'd1, 1'b0, 2); drainQueue();
`endif

    applyStimulus("tail_lw", 4'd1, 1'b1, 0); drainQueue();

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
